// File: rtl/isa_io_cycle_master.sv
// Host-side ISA I/O cycle initiator: one command in, one full ALE/AEN/IOR#/IOW# cycle out,
// with CHRDY wait-state stretching, a bounded wait timeout and registered bus outputs.
module isa_io_cycle_master #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int ALE_CYCLES    = 1,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int WAIT_TIMEOUT  = 64
) (
  input  logic                  isa_clk,
  input  logic                  isa_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] isa_addr,
  output logic [DATA_WIDTH-1:0] isa_data_out,
  output logic                  isa_data_oe,
  input  logic [DATA_WIDTH-1:0] isa_data_in,
  output logic                  isa_ale,
  output logic                  isa_aen,
  output logic                  isa_ior,
  output logic                  isa_iow,
  input  logic                  isa_chrdy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam int MAX_AS   = (ALE_CYCLES > SETUP_CYCLES) ? ALE_CYCLES : SETUP_CYCLES;
  localparam int MAX_PH   = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
  localparam int MAX_ASPH = (MAX_AS > MAX_PH) ? MAX_AS : MAX_PH;
  localparam int CNT_MAX  = (MAX_ASPH > WAIT_TIMEOUT) ? MAX_ASPH : WAIT_TIMEOUT;
  localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Each state's counter is loaded with its duration minus one and leaves on zero.
  localparam logic [CW-1:0] ALE_LD    = CW'(ALE_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LD   = CW'(WAIT_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    tmo_q, tmo_d;

  logic ale_q, ale_d;
  logic aen_q, aen_d;
  logic ior_q, ior_d;
  logic iow_q, iow_d;
  logic oe_q, oe_d;
  logic rsp_valid_q, rsp_valid_d;

  logic cnt_zero;
  logic strobe_d;
  logic own_d;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_ALE;
          cnt_d   = ALE_LD;
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          tmo_d   = 1'b0;
        end
      end
      S_ALE: begin
        if (cnt_zero) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (isa_chrdy) begin
          if (!write_q) rdata_d = isa_data_in;
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LD;
        end
      end
      S_WAIT: begin
        // A ready target on the final wait clock still completes normally.
        if (isa_chrdy) begin
          if (!write_q) rdata_d = isa_data_in;
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else if (cnt_zero) begin
          if (!write_q) rdata_d = '0;
          tmo_d   = 1'b1;
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus outputs are registered from the next state so they switch cleanly on the edge.
    strobe_d    = (state_d == S_STROBE) || (state_d == S_WAIT);
    own_d       = (state_d == S_ALE) || (state_d == S_SETUP) || strobe_d || (state_d == S_HOLD);
    ale_d       = (state_d == S_ALE);
    aen_d       = !own_d;
    ior_d       = !(strobe_d && !write_d);
    iow_d       = !(strobe_d && write_d);
    oe_d        = write_d && own_d && (state_d != S_ALE);
    rsp_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge isa_clk) begin
    if (isa_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      tmo_q       <= 1'b0;
      ale_q       <= 1'b0;
      aen_q       <= 1'b1;
      ior_q       <= 1'b1;
      iow_q       <= 1'b1;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      tmo_q       <= tmo_d;
      ale_q       <= ale_d;
      aen_q       <= aen_d;
      ior_q       <= ior_d;
      iow_q       <= iow_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_timeout  = tmo_q;
  assign isa_addr     = addr_q;
  assign isa_data_out = wdata_q;
  assign isa_data_oe  = oe_q;
  assign isa_ale      = ale_q;
  assign isa_aen      = aen_q;
  assign isa_ior      = ior_q;
  assign isa_iow      = iow_q;

endmodule

// File: tb/tb_isa_io_cycle_master.sv
// Bench for isa_io_cycle_master: directed table, back-to-back, mid-wait reset and random cycles
// checked clock by clock against a cycle-count model of the bus protocol.
module tb_isa_io_cycle_master;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int A  = 1;
  localparam int S  = 1;
  localparam int P  = 4;
  localparam int H  = 1;
  localparam int WT = 64;

  logic          isa_clk = 1'b0;
  logic          isa_reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_timeout;
  logic          busy;
  logic [AW-1:0] isa_addr;
  logic [DW-1:0] isa_data_out;
  logic          isa_data_oe;
  logic [DW-1:0] isa_data_in;
  logic          isa_ale;
  logic          isa_aen;
  logic          isa_ior;
  logic          isa_iow;
  logic          isa_chrdy;

  always #5 isa_clk = ~isa_clk;

  isa_io_cycle_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALE_CYCLES(A), .SETUP_CYCLES(S),
    .STROBE_CYCLES(P), .HOLD_CYCLES(H), .WAIT_TIMEOUT(WT)
  ) dut (
    .isa_clk(isa_clk), .isa_reset(isa_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy),
    .isa_addr(isa_addr), .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe),
    .isa_data_in(isa_data_in), .isa_ale(isa_ale), .isa_aen(isa_aen),
    .isa_ior(isa_ior), .isa_iow(isa_iow), .isa_chrdy(isa_chrdy)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lows;
    logic [DW-1:0] rdata;
    int            exp_total;
    bit            exp_tmo;
  } vec_t;

  vec_t          tbl[9];
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_rdata;
  logic          exp_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Extra strobe clocks: one per consecutive CHRDY-low sample from the last strobe clock, capped.
  function automatic int ref_extra(input int lows);
    return (lows > WT) ? WT : lows;
  endfunction

  function automatic bit ref_timeout(input int lows);
    return lows > WT;
  endfunction

  task automatic next_cycle();
    @(posedge isa_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".ready"}, cmd_ready, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 0);
    chk({tag, ".ale"}, isa_ale, 0);
    chk({tag, ".aen"}, isa_aen, 1);
    chk({tag, ".ior"}, isa_ior, 1);
    chk({tag, ".iow"}, isa_iow, 1);
    chk({tag, ".oe"}, isa_data_oe, 0);
  endtask

  // Cycle n = clock period after the n-th rising edge following the accept edge.
  task automatic run_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int lows, input logic [DW-1:0] rd,
                         input int tot, input bit t);
    int ps;
    int cap;
    ps  = A + S + P;
    cap = tot - H - 1;
    cmd_valid   = 1'b1;
    cmd_write   = w;
    cmd_addr    = a;
    cmd_wdata   = d;
    isa_chrdy   = 1'b1;
    isa_data_in = DW'($urandom);
    @(negedge isa_clk);
    chk("accept.ready", cmd_ready, 1);
    next_cycle();
    if (!w) exp_rdata = t ? '0 : rd;
    exp_tmo = t;
    for (int n = 1; n <= tot + 1; n++) begin
      cmd_valid = (n < tot) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      if (n >= ps && n < ps + lows) isa_chrdy = 1'b0;
      else if (n == ps + lows)      isa_chrdy = 1'b1;
      else                          isa_chrdy = 1'($urandom);
      isa_data_in = (n == cap) ? rd : DW'($urandom);
      @(negedge isa_clk);
      chk($sformatf("ale@%0d", n), isa_ale, (n <= A));
      chk($sformatf("aen@%0d", n), isa_aen, (n >= tot));
      chk($sformatf("ior@%0d", n), isa_ior, !(!w && n > A + S && n <= cap));
      chk($sformatf("iow@%0d", n), isa_iow, !(w && n > A + S && n <= cap));
      chk($sformatf("oe@%0d", n), isa_data_oe, (w && n > A && n < tot));
      chk($sformatf("rsp_valid@%0d", n), rsp_valid, (n == tot));
      chk($sformatf("ready@%0d", n), cmd_ready, (n > tot));
      chk($sformatf("busy@%0d", n), busy, (n <= tot));
      chk($sformatf("addr@%0d", n), isa_addr, a);
      chk($sformatf("wdata@%0d", n), isa_data_out, d);
      if (n >= tot) begin
        chk($sformatf("rdata@%0d", n), rsp_rdata, exp_rdata);
        chk($sformatf("timeout@%0d", n), rsp_timeout, exp_tmo);
      end
      next_cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors so far", n_vec);
    $fatal(1);
  end

  initial begin
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
    int            lows;

    tbl[0] = '{1'b0, 10'h0F0, 8'h00,   0, 8'h18,  8, 1'b0};
    tbl[1] = '{1'b1, 10'h100, 8'hA5,   0, 8'h33,  8, 1'b0};
    tbl[2] = '{1'b0, 10'h2A1, 8'h00,   3, 8'h3C, 11, 1'b0};
    tbl[3] = '{1'b0, 10'h155, 8'h00, 200, 8'h99, 72, 1'b1};
    tbl[4] = '{1'b0, 10'h0AA, 8'h00,  64, 8'h64, 72, 1'b0};
    tbl[5] = '{1'b0, 10'h3FF, 8'h00,  65, 8'h77, 72, 1'b1};
    tbl[6] = '{1'b0, 10'h3FF, 8'h00,   1, 8'h7E,  9, 1'b0};
    tbl[7] = '{1'b1, 10'h200, 8'h5C, 100, 8'h11, 72, 1'b1};
    tbl[8] = '{1'b1, 10'h100, 8'hA5,   2, 8'h22, 10, 1'b0};

    isa_reset   = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    isa_data_in = '0;
    isa_chrdy   = 1'b1;
    exp_rdata   = '0;
    exp_tmo     = 1'b0;

    next_cycle();
    next_cycle();
    @(negedge isa_clk);
    check_idle("reset");
    chk("reset.rdata", rsp_rdata, 0);
    chk("reset.timeout", rsp_timeout, 0);
    chk("reset.addr", isa_addr, 0);
    chk("reset.data_out", isa_data_out, 0);
    next_cycle();
    isa_reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lows, tbl[i].rdata,
              tbl[i].exp_total, tbl[i].exp_tmo);

    // Back-to-back: cmd_valid stays high, second command waits for DONE plus one IDLE clock.
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_addr    = 10'h100;
    cmd_wdata   = 8'h5A;
    isa_chrdy   = 1'b1;
    isa_data_in = 8'hC3;
    @(negedge isa_clk);
    chk("b2b.ready0", cmd_ready, 1);
    next_cycle();
    cmd_write = 1'b0;
    cmd_addr  = 10'h13E;
    cmd_wdata = 8'hFF;
    for (int n = 1; n <= 18; n++) begin
      if (n == 10) cmd_valid = 1'b0;
      @(negedge isa_clk);
      chk($sformatf("b2b.rsp_valid@%0d", n), rsp_valid, (n == 8 || n == 17));
      chk($sformatf("b2b.ready@%0d", n), cmd_ready, (n == 9 || n == 18));
      chk($sformatf("b2b.ale@%0d", n), isa_ale, (n == 1 || n == 10));
      chk($sformatf("b2b.addr@%0d", n), isa_addr, (n <= 9) ? 10'h100 : 10'h13E);
      chk($sformatf("b2b.ior@%0d", n), isa_ior, !(n >= 12 && n <= 15));
      chk($sformatf("b2b.iow@%0d", n), isa_iow, !(n >= 3 && n <= 6));
      if (n == 17) chk("b2b.rdata", rsp_rdata, 8'hC3);
      next_cycle();
    end
    exp_rdata = 8'hC3;

    // Reset while the strobe is stretched in a wait state.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 10'h055;
    @(negedge isa_clk);
    chk("rstwait.ready0", cmd_ready, 1);
    next_cycle();
    cmd_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      isa_chrdy = (n >= A + S + P) ? 1'b0 : 1'b1;
      if (n == 10) isa_reset = 1'b1;
      @(negedge isa_clk);
      if (n == 10) chk("rstwait.ior_before", isa_ior, 0);
      next_cycle();
    end
    isa_reset = 1'b0;
    isa_chrdy = 1'b1;
    @(negedge isa_clk);
    check_idle("rstwait.after");
    chk("rstwait.addr", isa_addr, 0);
    chk("rstwait.timeout", rsp_timeout, 0);
    chk("rstwait.rdata", rsp_rdata, 0);
    for (int n = 0; n < 12; n++) begin
      next_cycle();
      @(negedge isa_clk);
      chk($sformatf("rstwait.no_rsp@%0d", n), rsp_valid, 0);
    end
    next_cycle();
    exp_rdata = '0;
    exp_tmo   = 1'b0;

    for (int i = 0; i < 40; i++) begin
      w    = 1'($urandom);
      a    = AW'($urandom);
      d    = DW'($urandom);
      rd   = DW'($urandom);
      lows = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 4));
      run_txn(w, a, d, lows, rd, A + S + P + H + 1 + ref_extra(lows), ref_timeout(lows));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
